// File: rtl/trash_seq.sv
// trash_seq: instruction sequencer for the 8-word trash CPU.
// Holds program store, PC, 4x8 register file and 16x8 data memory.
module trash_seq #(
    parameter int PROG_AW = 3,
    parameter int DATA_AW = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_valid,
    input  logic [14:0]        prog_data,
    input  logic               run,
    input  logic               stop,
    output logic               busy,
    output logic [PROG_AW-1:0] pc,
    output logic               alu_start,
    output logic [3:0]         alu_op,
    output logic [3:0]         alu_a,
    output logic [3:0]         alu_b,
    input  logic               alu_done,
    input  logic [7:0]         alu_res,
    output logic               out_valid,
    output logic [7:0]         out_data
);

    localparam int PD = 1 << PROG_AW;
    localparam int DD = 1 << DATA_AW;
    localparam logic [PROG_AW-1:0] PC_ONE = 1;

    localparam logic [2:0] OP_NOOP   = 3'd0;
    localparam logic [2:0] OP_STORE  = 3'd1;
    localparam logic [2:0] OP_CALC   = 3'd2;
    localparam logic [2:0] OP_MSTORE = 3'd3;
    localparam logic [2:0] OP_MLOAD  = 3'd4;
    localparam logic [2:0] OP_JUMP   = 3'd5;
    localparam logic [2:0] OP_JUMPIF = 3'd6;
    localparam logic [2:0] OP_OUT    = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [PROG_AW-1:0] pc_q, pc_d;
    logic [PROG_AW-1:0] ld_ptr_q, ld_ptr_d;
    logic [14:0]        ir_q, ir_d;
    logic               stop_q, stop_d;
    logic [7:0]         rf_q [4];
    logic [7:0]         rf_d [4];
    logic [7:0]         mem_q [DD];
    logic [7:0]         mem_d [DD];
    logic [14:0]        prog_q [PD];
    logic               prog_we;

    logic               alu_start_q, alu_start_d;
    logic [3:0]         alu_op_q, alu_op_d;
    logic [3:0]         alu_a_q, alu_a_d;
    logic [3:0]         alu_b_q, alu_b_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_data_q, out_data_d;

    logic [2:0]         f_op;
    logic [3:0]         f_a;
    logic [7:0]         f_d;
    logic [1:0]         f_s;
    logic [1:0]         f_t;
    logic [PROG_AW-1:0] pc_inc;

    assign f_op   = ir_q[2:0];
    assign f_a    = ir_q[6:3];
    assign f_d    = ir_q[14:7];
    assign f_s    = f_d[5:4];
    assign f_t    = f_d[1:0];
    assign pc_inc = pc_q + PC_ONE;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ld_ptr_d    = ld_ptr_q;
        ir_d        = ir_q;
        stop_d      = stop_q;
        rf_d        = rf_q;
        mem_d       = mem_q;
        prog_we     = 1'b0;
        alu_start_d = 1'b0;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;

        unique case (state_q)
            S_IDLE: begin
                // a load in the same cycle as run wins; run is dropped
                if (prog_valid) begin
                    prog_we  = 1'b1;
                    ld_ptr_d = ld_ptr_q + PC_ONE;
                end else if (run) begin
                    pc_d     = '0;
                    ld_ptr_d = '0;
                    state_d  = S_FETCH;
                end
            end

            S_FETCH: begin
                ir_d    = prog_q[pc_q];
                state_d = stop ? S_IDLE : S_EXEC;
            end

            S_EXEC: begin
                state_d = stop ? S_IDLE : S_FETCH;
                pc_d    = pc_inc;
                unique case (f_op)
                    OP_NOOP: ;
                    OP_STORE: rf_d[f_a[1:0]] = f_d;
                    OP_CALC: begin
                        // a stopped CALC never issues its ALU request
                        pc_d = pc_q;
                        if (!stop) begin
                            alu_start_d = 1'b1;
                            alu_op_d    = f_a;
                            alu_a_d     = rf_q[f_s][7:4];
                            alu_b_d     = rf_q[f_s][3:0];
                            state_d     = S_WAIT;
                        end
                    end
                    OP_MSTORE: mem_d[f_a[DATA_AW-1:0]] = f_d;
                    OP_MLOAD: rf_d[f_s] = mem_q[f_a[DATA_AW-1:0]];
                    OP_JUMP: pc_d = f_a[PROG_AW-1:0];
                    OP_JUMPIF: begin
                        if (rf_q[f_s] == rf_q[f_t]) begin
                            pc_d = f_a[PROG_AW-1:0];
                        end
                    end
                    OP_OUT: begin
                        out_valid_d = 1'b1;
                        out_data_d  = rf_q[f_a[1:0]];
                    end
                endcase
            end

            S_WAIT: begin
                if (stop) begin
                    stop_d = 1'b1;
                end
                if (alu_done) begin
                    rf_d[f_t] = alu_res;
                    pc_d      = pc_inc;
                    stop_d    = 1'b0;
                    state_d   = (stop_q || stop) ? S_IDLE : S_FETCH;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ld_ptr_q    <= '0;
            ir_q        <= '0;
            stop_q      <= 1'b0;
            alu_start_q <= 1'b0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
            for (int i = 0; i < DD; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ld_ptr_q    <= ld_ptr_d;
            ir_q        <= ir_d;
            stop_q      <= stop_d;
            alu_start_q <= alu_start_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rf_q        <= rf_d;
            mem_q       <= mem_d;
        end
    end

    // program store has no reset; contents are undefined until loaded
    always_ff @(posedge clk) begin
        if (prog_we) begin
            prog_q[ld_ptr_q] <= prog_data;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign pc        = pc_q;
    assign alu_start = alu_start_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_trash_seq.sv
// Testbench for trash_seq: instruction-level reference model feeding
// a scoreboard of expected ALU requests and output strobes.
module tb_trash_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        prog_valid = 1'b0;
    logic [14:0] prog_data = '0;
    logic        run = 1'b0;
    logic        stop = 1'b0;
    logic        busy;
    logic [2:0]  pc;
    logic        alu_start;
    logic [3:0]  alu_op, alu_a, alu_b;
    logic        alu_done = 1'b0;
    logic [7:0]  alu_res = '0;
    logic        out_valid;
    logic [7:0]  out_data;

    trash_seq #(.PROG_AW(3), .DATA_AW(4)) dut (
        .clk(clk), .reset(reset),
        .prog_valid(prog_valid), .prog_data(prog_data),
        .run(run), .stop(stop), .busy(busy), .pc(pc),
        .alu_start(alu_start), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_res(alu_res),
        .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_alu;
        logic [2:0] pc;
        logic [11:0] data;
    } ev_t;

    ev_t         exq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          out_times[$];
    int          alu_delay = 1;
    logic [14:0] tb_prog[8];
    logic [14:0] stage[8];
    logic [2:0]  tb_ld = '0;
    logic [7:0]  mrf[4];
    logic [7:0]  mmem[16];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [14:0] enc(input logic [2:0] op,
                                        input logic [3:0] a,
                                        input logic [7:0] d);
        return {d, a, op};
    endfunction

    function automatic logic [7:0] alu_f(input logic [3:0] op,
                                         input logic [3:0] a,
                                         input logic [3:0] b);
        if (op == 4'd0) return {4'h0, a} + {4'h0, b};
        return {op ^ a, b + op};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mrf[i] = '0;
        for (int i = 0; i < 16; i++) mmem[i] = '0;
    endtask

    // executes n instructions of tb_prog from PC 0, queueing observables
    task automatic model_run(input int n);
        logic [2:0]  p;
        logic [14:0] w;
        logic [3:0]  a, ha, hb;
        logic [7:0]  d;
        logic [1:0]  s, t;
        ev_t         e;
        p = '0;
        for (int i = 0; i < n; i++) begin
            w = tb_prog[p];
            a = w[6:3];
            d = w[14:7];
            s = d[5:4];
            t = d[1:0];
            case (w[2:0])
                3'd1: mrf[a[1:0]] = d;
                3'd2: begin
                    ha = mrf[s][7:4];
                    hb = mrf[s][3:0];
                    e.is_alu = 1'b1;
                    e.pc = p;
                    e.data = {a, ha, hb};
                    exq.push_back(e);
                    mrf[t] = alu_f(a, ha, hb);
                end
                3'd3: mmem[a] = d;
                3'd4: mrf[s] = mmem[a];
                default: ;
            endcase
            case (w[2:0])
                3'd5: p = a[2:0];
                3'd6: p = (mrf[s] == mrf[t]) ? a[2:0] : p + 3'd1;
                default: p = p + 3'd1;
            endcase
            if (w[2:0] == 3'd7) begin
                e.is_alu = 1'b0;
                e.pc = p;
                e.data = {4'h0, mrf[a[1:0]]};
                exq.push_back(e);
            end
        end
    endtask

    // monitor: pops one expectation for every DUT observable
    always @(negedge clk) begin : mon
        ev_t e;
        if (!reset && (out_valid || alu_start)) begin
            if (exq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got alu=%0b out=%0b expected none",
                         alu_start, out_valid);
            end else begin
                e = exq.pop_front();
                check("event_kind", {31'd0, alu_start}, {31'd0, e.is_alu});
                check("event_pc", {29'd0, pc}, {29'd0, e.pc});
                if (alu_start)
                    check("alu_req", {20'd0, alu_op, alu_a, alu_b}, {20'd0, e.data});
                else
                    check("out_data", {24'd0, out_data}, {20'd0, e.data});
            end
            if (out_valid) out_times.push_back(cyc);
        end
    end

    // ALU model: answers alu_delay cycles after each request
    initial begin : alu_model
        logic [3:0] o, a, b;
        forever begin
            @(negedge clk);
            if (alu_start && !reset) begin
                o = alu_op;
                a = alu_a;
                b = alu_b;
                repeat (alu_delay) @(posedge clk);
                #1;
                if (busy)
                    check("alu_hold", {20'd0, alu_op, alu_a, alu_b}, {20'd0, o, a, b});
                alu_res  = alu_f(o, a, b);
                alu_done = 1'b1;
                @(posedge clk);
                #1;
                alu_done = 1'b0;
                alu_res  = 8'($urandom);
            end
        end
    end

    task automatic check_outs_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_pc"}, {29'd0, pc}, 0);
        check({tag, "_alu_start"}, {31'd0, alu_start}, 0);
        check({tag, "_alu_op"}, {28'd0, alu_op}, 0);
        check({tag, "_alu_a"}, {28'd0, alu_a}, 0);
        check({tag, "_alu_b"}, {28'd0, alu_b}, 0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 0);
        check({tag, "_out_data"}, {24'd0, out_data}, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        prog_valid = 1'b0;
        run = 1'b0;
        stop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tb_ld = '0;
        model_reset();
        exq.delete();
    endtask

    task automatic load_word(input logic [14:0] w);
        prog_valid = 1'b1;
        prog_data = w;
        tb_prog[tb_ld] = w;
        tb_ld = tb_ld + 3'd1;
        @(posedge clk);
        #1;
        prog_valid = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 8; i++) load_word(stage[i]);
    endtask

    task automatic start_run();
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        tb_ld = '0;
        check("busy_rise", {31'd0, busy}, 1);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exq.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("drain_left", exq.size(), 0);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("idle_reached", {31'd0, busy}, 0);
    endtask

    task automatic finish_run();
        do_stop();
        wait_idle(30);
        exq.delete();
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k;
        logic [7:0] v;
        #1 reset = 1'b1;
        #2 check_outs_zero("reset");
        do_reset();

        // STORE r1, OUT r1, JUMP 1: strobe every 4 cycles
        stage = '{enc(1, 1, 8'h5A), enc(7, 1, 0), enc(5, 1, 0), 15'd0,
                  15'd0, 15'd0, 15'd0, 15'd0};
        load_all();
        model_run(9);
        out_times.delete();
        start_run();
        wait_drain(80);
        check("out_count", out_times.size(), 4);
        for (int i = 1; i < out_times.size(); i++)
            check("out_period", out_times[i] - out_times[i-1], 4);
        finish_run();

        // CALC with a 3-cycle ALU
        do_reset();
        alu_delay = 3;
        stage = '{enc(1, 0, 8'h34), enc(2, 0, 8'h02), enc(7, 2, 0),
                  enc(5, 3, 0), 15'd0, 15'd0, 15'd0, 15'd0};
        load_all();
        model_run(3);
        start_run();
        wait_drain(60);
        finish_run();

        // MEMSTORE/MEMLOAD and JUMPIF taken / not taken
        for (int r = 0; r < 2; r++) begin
            do_reset();
            v = (r == 0) ? 8'hC3 : 8'hC4;
            stage = '{enc(3, 9, 8'hC3), enc(4, 9, 8'h30), enc(1, 0, v),
                      enc(6, 6, 8'h30), enc(7, 0, 0), enc(5, 5, 0),
                      enc(7, 3, 0), enc(5, 7, 0)};
            load_all();
            model_run(6);
            start_run();
            wait_drain(60);
            finish_run();
        end

        // stop during ALU_WAIT, then observe r3 and PC
        do_reset();
        alu_delay = 4;
        stage = '{enc(1, 1, 8'h21), enc(2, 5, 8'h13), 15'd0, 15'd0,
                  15'd0, 15'd0, 15'd0, 15'd0};
        load_all();
        model_run(2);
        start_run();
        wait_drain(60);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        check("stop_wait_busy1", {31'd0, busy}, 1);
        @(posedge clk);
        #1;
        check("stop_wait_busy2", {31'd0, busy}, 1);
        wait_idle(20);
        check("pc_after_stop", {29'd0, pc}, 2);
        exq.delete();
        stage = '{enc(7, 3, 0), enc(5, 1, 0), 15'd0, 15'd0,
                  15'd0, 15'd0, 15'd0, 15'd0};
        load_all();
        model_run(2);
        start_run();
        wait_drain(60);
        finish_run();

        // ninth word overwrites address 0
        stage = '{enc(7, 1, 0), enc(5, 1, 0), 15'd0, 15'd0,
                  15'd0, 15'd0, 15'd0, 15'd0};
        load_all();
        load_word(enc(7, 3, 0));
        model_run(2);
        start_run();
        wait_drain(60);
        finish_run();

        // run together with prog_valid is dropped
        stage = '{enc(7, 1, 0), enc(5, 1, 0), 15'd0, 15'd0,
                  15'd0, 15'd0, 15'd0, 15'd0};
        for (int i = 0; i < 7; i++) load_word(stage[i]);
        prog_valid = 1'b1;
        prog_data = stage[7];
        run = 1'b1;
        tb_prog[tb_ld] = stage[7];
        tb_ld = tb_ld + 3'd1;
        @(posedge clk);
        #1;
        prog_valid = 1'b0;
        run = 1'b0;
        check("run_pv_busy", {31'd0, busy}, 0);
        model_run(2);
        start_run();
        wait_drain(60);
        finish_run();

        // asynchronous reset while alu_start is high
        do_reset();
        alu_delay = 2;
        stage = '{enc(1, 0, 8'h34), enc(2, 0, 8'h02), enc(7, 2, 0),
                  enc(5, 3, 0), 15'd0, 15'd0, 15'd0, 15'd0};
        load_all();
        model_run(2);
        start_run();
        k = 0;
        while (!alu_start && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("alu_start_seen", {31'd0, alu_start}, 1);
        #1 reset = 1'b1;
        #1 check_outs_zero("async_rst");
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_busy", {31'd0, busy}, 0);
        check("post_rst_pc", {29'd0, pc}, 0);
        model_reset();
        exq.delete();
        tb_ld = '0;
        stage = '{enc(7, 0, 0), enc(7, 1, 0), enc(7, 2, 0), enc(7, 3, 0),
                  enc(5, 4, 0), 15'd0, 15'd0, 15'd0};
        load_all();
        model_run(4);
        start_run();
        wait_drain(60);
        finish_run();

        // random programs
        for (int r = 0; r < 25; r++) begin
            do_reset();
            alu_delay = $urandom_range(1, 4);
            for (int i = 0; i < 8; i++)
                stage[i] = enc(3'($urandom_range(0, 7)), 4'($urandom),
                               8'($urandom));
            load_all();
            model_run(400);
            start_run();
            repeat ($urandom_range(40, 160)) @(posedge clk);
            #1;
            finish_run();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trash_seq.md
# trash_seq

Instruction sequencer for the 8-byte-program trash CPU. It holds the program store, program counter, 4×8 register file and 16×8 data memory. It loads a program word-by-word, then runs a fetch/execute state machine that drives the shared 4-bit ALU through a start/done handshake. Its outputs feed the dedicated output pins through the top-level wrapper.

## Interface
- `PROG_AW`, 3: program-store address width; depth is 2^PROG_AW; the PC is this wide.
- `DATA_AW`, 4: data-memory address width; depth is 2^DATA_AW.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `prog_valid`  in  1  write `prog_data` into the program store at the load pointer.
- `prog_data`  in  15  instruction word.
- `run`  in  1  start execution at PC 0.
- `stop`  in  1  return to IDLE.
- `busy`  out  1  high in any state other than IDLE.
- `pc`  out  PROG_AW  current program counter.
- `alu_start`  out  1  one-cycle ALU request.
- `alu_op`  out  4  ALU opcode.
- `alu_a`, `alu_b`  out  4 each  ALU operands.
- `alu_done`  in  1  ALU result valid.
- `alu_res`  in  8  ALU result.
- `out_valid`  out  1  one-cycle strobe marking new `out_data`.
- `out_data`  out  8  output register value.

## Operation
- Instruction fields: OP = [2:0], A = [6:3], D = [14:7]. Within D, S = D[5:4] and T = D[1:0].
- Opcodes:
  - 0 NOOP: no effect.
  - 1 STORE: r[A[1:0]] ← D.
  - 2 CALC: `alu_op` = A, `alu_a` = r[S][7:4], `alu_b` = r[S][3:0]; on done, r[T] ← `alu_res`.
  - 3 MEMSTORE: mem[A] ← D.
  - 4 MEMLOAD: r[S] ← mem[A].
  - 5 JUMP: PC ← A[PROG_AW-1:0].
  - 6 JUMPIF: PC ← A[PROG_AW-1:0] if r[S] == r[T]; otherwise PC+1.
  - 7 OUT: `out_data` ← r[A[1:0]]; `out_valid` pulses.
- States and transitions:
  - IDLE: go to FETCH on `run`.
  - FETCH: load IR ← prog[PC]; go to EXEC.
  - EXEC: perform the operation and update PC; go to FETCH. For CALC, go to ALU_WAIT instead.
  - ALU_WAIT: on `alu_done`, write r[T] and set PC+1; go to FETCH.
- Loading:
  - Loading happens only in IDLE. `prog_valid` writes prog[ld_ptr], then ld_ptr increments and wraps 7→0.
  - `prog_valid` is ignored outside IDLE.
- `run` behaviour:
  - In IDLE, `run` sets PC ← 0 and ld_ptr ← 0.
  - If `run` and `prog_valid` are high in the same cycle: the write happens and `run` is ignored.
  - `run` outside IDLE is ignored.
- PC increments wrap 7→0. Execution never self-terminates; only `stop` or `reset` ends it.
- `stop` behaviour:
  - In FETCH or EXEC: go to IDLE at the next edge. The EXEC instruction in flight still commits its register, memory and output effects.
  - In ALU_WAIT: `stop` is latched, and the block goes to IDLE on `alu_done` after writing r[T].
- `alu_done` outside ALU_WAIT is ignored. `alu_res` is sampled only in the cycle `alu_done` is high.
- Register file and data memory are only ever written by the sequencer. Program-store contents are undefined until loaded.

## Timing
- Reset values:
  - Outputs: `busy`=0, `pc`=0, `alu_start`=0, `alu_op`=0, `alu_a`=0, `alu_b`=0, `out_valid`=0, `out_data`=0.
  - Internal: state IDLE, ld_ptr=0, IR=0, stop latch cleared, r0–r3=0, all memory bytes=0.
- Non-CALC instructions take 2 cycles (FETCH + EXEC).
- CALC takes 3+N cycles, where N is the number of cycles between `alu_start` and `alu_done` (N ≥ 1).
- `alu_start` is registered: it is high for exactly the one cycle after the EXEC edge of a CALC.
- `alu_op`, `alu_a` and `alu_b` are valid with `alu_start` and held stable until `alu_done`.
- `out_valid` is high exactly one cycle, the cycle after OUT's EXEC edge, with `out_data` valid in that cycle. `out_data` then holds until the next OUT.
- STORE, MEMLOAD and MEMSTORE writes are visible to an instruction fetched on the next FETCH.
- A JUMPIF compare uses register values after all previous writes.
- `busy` rises the cycle after `run` and falls the cycle after the transition to IDLE.
- Asynchronous reset mid-operation:
  - Every output returns to its reset value immediately.
  - `alu_start` drops at once.
  - A pending ALU result is discarded.

## Test plan
- Load and output: load STORE r1←0x5A, OUT r1, JUMP 1, then `run` → `out_valid` pulses with `out_data`=0x5A every 4 cycles. `pc` sequence 0,1,2,1,2…
- CALC: STORE r0←0x34, CALC op=0 S=0 T=2, OUT r2; ALU model answers after 3 cycles with 0x07 → `alu_a`=3, `alu_b`=4 held during wait; `out_data`=0x07.
- Memory and branch: MEMSTORE mem[9]←0xC3, MEMLOAD r3←mem[9], STORE r0←0xC3, JUMPIF 6 S=3 T=0 → PC=6. Repeat with r0=0xC4 → PC=4.
- `stop` during ALU_WAIT: assert `stop` while waiting → `busy` stays high until `alu_done`, r[T] is written, then IDLE. Loading 8 words then a 9th → word 9 overwrites address 0.
- Reset mid-CALC while `alu_start` is high → all outputs 0 immediately. A later `alu_done` is ignored; r0–r3=0.
- `run` with `prog_valid` in the same cycle → word written, `busy` stays 0. `run` in the next cycle → starts at PC 0.
